// File: rtl/sram_responder_pkg.sv
// Shared types for the SRAM responder model.
// FSM states, bus command encoding and latency bounds.
package sram_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR_WAIT,
    S_RD_WAIT,
    S_RD_DRIVE
  } state_e;

  typedef enum logic [1:0] {
    CMD_NOP,
    CMD_RD,
    CMD_WR
  } cmd_e;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 7;

  // WE_N wins over OE_N, so a write with OE_N low is still a write.
  function automatic cmd_e decode_cmd(
    input logic ce_n,
    input logic we_n,
    input logic oe_n
  );
    cmd_e c;
    c = CMD_NOP;
    if (!ce_n && !we_n)
      c = CMD_WR;
    else if (!ce_n && !oe_n)
      c = CMD_RD;
    return c;
  endfunction

  function automatic int clamp_lat(input int lat);
    int r;
    r = lat;
    if (r < LAT_MIN) r = LAT_MIN;
    if (r > LAT_MAX) r = LAT_MAX;
    return r;
  endfunction

endpackage

// File: rtl/sram_responder_array.sv
// Word storage for the SRAM responder.
// Byte-lane write enables, combinational read.
module sram_resp_array #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int HW = DW / 2;

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we[1]) mem[addr][DW-1:HW] <= wdata[DW-1:HW];
    if (we[0]) mem[addr][HW-1:0]  <= wdata[HW-1:0];
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sram_responder.sv
// Clocked device-side model of a 256K x 16 async SRAM.
// Lane-masked writes, latency-delayed reads, fault flags.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 2,
  parameter int WR_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic              busy,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic              contention,
  output logic              oob_err
);

  localparam int HALF = DATA_W / 2;
  localparam int RD_L = clamp_lat(RD_LAT);
  localparam int WR_L = clamp_lat(WR_LAT);
  localparam logic [2:0] RD_RLD = 3'(RD_L - 1);
  localparam logic [2:0] WR_RLD = 3'(WR_L - 1);

  state_e state, nxt;
  cmd_e   cmd;

  logic [2:0]        cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic cap, wr_go, rd_hit, cont;
  logic addr_oob, addr_chg, oob_q;
  logic wr_commit, drive;

  logic [1:0]            we;
  logic [DEPTH_LOG2-1:0] arr_addr;
  logic [DATA_W-1:0]     arr_rdata, rd_word;

  assign cmd      = decode_cmd(SRAM_CE_N, SRAM_WE_N, SRAM_OE_N);
  assign addr_oob = |SRAM_ADDR[ADDR_W-1:DEPTH_LOG2];
  assign oob_q    = |addr_q[ADDR_W-1:DEPTH_LOG2];
  assign addr_chg = SRAM_ADDR != addr_q;

  always_comb begin
    nxt    = state;
    cnt_d  = cnt;
    addr_d = addr_q;
    cap    = 1'b0;
    wr_go  = 1'b0;
    rd_hit = 1'b0;
    cont   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd == CMD_WR) begin
          cap   = 1'b1;
          wr_go = 1'b1;
          nxt   = S_WR_WAIT;
          cnt_d = WR_RLD;
        end else if (cmd == CMD_RD) begin
          cap = 1'b1;
          if (RD_L == 1) begin
            nxt    = S_RD_DRIVE;
            rd_hit = 1'b1;
          end else begin
            nxt   = S_RD_WAIT;
            cnt_d = RD_RLD;
          end
        end
      end
      S_WR_WAIT: begin
        if (cnt == '0) nxt = S_IDLE;
        else cnt_d = cnt - 3'd1;
      end
      S_RD_WAIT: begin
        if (addr_chg) begin
          cap   = 1'b1;
          cnt_d = RD_RLD;
        end else if (cnt == '0) begin
          nxt    = S_RD_DRIVE;
          rd_hit = 1'b1;
        end else begin
          cnt_d = cnt - 3'd1;
        end
      end
      S_RD_DRIVE: begin
        if (cmd == CMD_WR) begin
          cont = 1'b1;
          nxt  = S_IDLE;
        end else if (cmd != CMD_RD) begin
          nxt = S_IDLE;
        end else if (addr_chg) begin
          cap = 1'b1;
          // A one-cycle latency re-enters drive directly as a new read.
          if (RD_L == 1) begin
            rd_hit = 1'b1;
          end else begin
            nxt   = S_RD_WAIT;
            cnt_d = RD_RLD;
          end
        end
      end
      default: nxt = S_IDLE;
    endcase
    if (cap) addr_d = SRAM_ADDR;
  end

  assign wr_commit = wr_go && !addr_oob;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      rd_count   <= '0;
      wr_count   <= '0;
      contention <= 1'b0;
      oob_err    <= 1'b0;
    end else begin
      state  <= nxt;
      cnt    <= cnt_d;
      addr_q <= addr_d;
      if (wr_commit && wr_count != '1)
        wr_count <= wr_count + 16'd1;
      if (rd_hit && rd_count != '1)
        rd_count <= rd_count + 16'd1;
      if (cont)
        contention <= 1'b1;
      if (cap && addr_oob)
        oob_err <= 1'b1;
    end
  end

  // Reset gates the write strobe so a held write never lands.
  assign we = {2{wr_commit && rst}} & {~SRAM_UB_N, ~SRAM_LB_N};

  assign arr_addr = (state == S_IDLE) ?
    SRAM_ADDR[DEPTH_LOG2-1:0] : addr_q[DEPTH_LOG2-1:0];

  sram_resp_array #(
    .AW (DEPTH_LOG2),
    .DW (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .addr  (arr_addr),
    .wdata (SRAM_DQ),
    .rdata (arr_rdata)
  );

  assign busy    = state != S_IDLE;
  assign drive   = state == S_RD_DRIVE;
  assign rd_word = oob_q ? '0 : arr_rdata;

  assign SRAM_DQ[DATA_W-1:HALF] = (drive && !SRAM_UB_N) ?
    rd_word[DATA_W-1:HALF] : {HALF{1'bz}};
  assign SRAM_DQ[HALF-1:0] = (drive && !SRAM_LB_N) ?
    rd_word[HALF-1:0] : {HALF{1'bz}};

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder.
// Released DQ lanes read back as ones through pullups.
module tb_sram_responder;

  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [17:0] addr = '0;
  logic ub_n = 1'b0, lb_n = 1'b0;
  logic we_n = 1'b1, ce_n = 1'b1, oe_n = 1'b1;
  logic [15:0] tb_dq = '0;
  logic tb_en = 1'b0;
  wire  [15:0] dq;

  logic busy, contention, oob_err;
  logic [15:0] rd_count, wr_count;

  logic [17:0] f_addr = '0;
  logic f_ce_n = 1'b1, f_oe_n = 1'b1;
  wire  [15:0] f_dq;
  logic f_busy, f_cont, f_oob;
  logic [15:0] f_rd_count, f_wr_count;

  assign dq = tb_en ? tb_dq : 16'hzzzz;

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (dq[g]);
  end

  always #5 clk = ~clk;

  sram_responder #(.RD_LAT(RD_LAT), .WR_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .SRAM_DQ(dq), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .busy(busy),
    .rd_count(rd_count), .wr_count(wr_count),
    .contention(contention), .oob_err(oob_err)
  );

  sram_responder #(.RD_LAT(1), .WR_LAT(1)) u_fast (
    .clk(clk), .rst(rst), .SRAM_DQ(f_dq), .SRAM_ADDR(f_addr),
    .SRAM_UB_N(1'b0), .SRAM_LB_N(1'b0), .SRAM_WE_N(1'b1),
    .SRAM_CE_N(f_ce_n), .SRAM_OE_N(f_oe_n), .busy(f_busy),
    .rd_count(f_rd_count), .wr_count(f_wr_count),
    .contention(f_cont), .oob_err(f_oob)
  );

  typedef struct {
    int          due;
    logic [15:0] exp;
    string       name;
  } rd_exp_t;

  rd_exp_t sb[$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] mem [1024];
  int   m_wr = 0, m_rd = 0;
  logic m_oob = 1'b0, m_cont = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, exp);
  endtask

  // Read-data monitor: DQ must still be released one cycle before
  // the due cycle and carry the expected word on it.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      if (sb[0].due == cyc + 1)
        chk({sb[0].name, "_early"}, dq, 16'hFFFF);
      if (sb[0].due == cyc) begin
        rd_exp_t e;
        e = sb.pop_front();
        chk(e.name, dq, e.exp);
      end else if (sb[0].due < cyc) begin
        rd_exp_t e;
        e = sb.pop_front();
        chk({e.name, "_missed"}, 16'hDEAD, e.exp);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_pins();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
    ub_n = 1'b0; lb_n = 1'b0; tb_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    chk("idle", {15'd0, busy}, 16'h0);
  endtask

  function automatic logic [15:0] exp_word(input logic [17:0] a,
                                           input logic u, input logic l);
    logic [15:0] w;
    w = (|a[17:10]) ? 16'h0000 : mem[a[9:0]];
    if (u) w[15:8] = 8'hFF;
    if (l) w[7:0]  = 8'hFF;
    return w;
  endfunction

  task automatic chk_cnt(input string tag);
    chk({tag, "_wr_count"}, wr_count, 16'(m_wr));
    chk({tag, "_rd_count"}, rd_count, 16'(m_rd));
    chk({tag, "_flags"}, {14'd0, contention, oob_err}, {14'd0, m_cont, m_oob});
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d,
                    input logic u, input logic l);
    addr = a; ub_n = u; lb_n = l;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    tb_dq = d; tb_en = 1'b1;
    step();
    idle_pins();
    if (|a[17:10]) begin
      m_oob = 1'b1;
    end else begin
      if (!u) mem[a[9:0]][15:8] = d[15:8];
      if (!l) mem[a[9:0]][7:0]  = d[7:0];
      if (m_wr < 65535) m_wr++;
    end
    wait_idle();
  endtask

  task automatic rd_issue(input logic [17:0] a, input logic u, input logic l,
                          input string name, output int due);
    rd_exp_t e;
    addr = a; ub_n = u; lb_n = l;
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
    due = cyc + 1 + RD_LAT;
    e.due = due;
    e.exp = exp_word(a, u, l);
    e.name = name;
    sb.push_back(e);
    if (m_rd < 65535) m_rd++;
    if (|a[17:10]) m_oob = 1'b1;
  endtask

  task automatic rd(input logic [17:0] a, input logic u, input logic l,
                    input string name);
    int due;
    rd_issue(a, u, l, name, due);
    while (cyc < due) step();
    idle_pins();
    wait_idle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int due;
    logic [17:0] ra [8];

    // Reset held with a write pattern on the bus
    rst = 1'b0; addr = 18'h4; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    repeat (3) step();
    chk("rst_dq", dq, 16'hFFFF);
    chk("rst_busy", {15'd0, busy}, 16'h0);
    chk_cnt("rst");
    idle_pins();
    step();
    rst = 1'b1;
    step();

    wr(18'h004, 16'hBEEF, 1'b0, 1'b0);
    rd(18'h004, 1'b0, 1'b0, "rd_beef");
    chk_cnt("wr_rd");

    // Reset under a write to the same word must not disturb it
    addr = 18'h004; ce_n = 1'b0; we_n = 1'b0;
    tb_dq = 16'h0000; tb_en = 1'b1;
    rst = 1'b0;
    repeat (3) step();
    idle_pins();
    step();
    rst = 1'b1;
    m_wr = 0; m_rd = 0; m_oob = 1'b0; m_cont = 1'b0;
    step();
    chk_cnt("rst2");
    rd(18'h004, 1'b0, 1'b0, "rd_after_rst");

    wr(18'h010, 16'h1234, 1'b0, 1'b0);
    wr(18'h010, 16'hAB00, 1'b0, 1'b1);
    rd(18'h010, 1'b0, 1'b0, "lanes_full");
    rd(18'h010, 1'b1, 1'b0, "lanes_lb_only");
    chk_cnt("lanes");

    // Address switch during the wait restarts the latency
    addr = 18'h004; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
    step();
    rd_issue(18'h010, 1'b0, 1'b0, "addr_switch", due);
    while (cyc < due) step();
    idle_pins();
    wait_idle();
    chk_cnt("switch");

    // Write strobe while the responder drives DQ
    rd_issue(18'h004, 1'b0, 1'b0, "pre_cont", due);
    while (cyc < due) step();
    we_n = 1'b0; tb_dq = 16'h5555; tb_en = 1'b1;
    step();
    chk("cont_flag", {15'd0, contention}, 16'h1);
    chk("cont_busy", {15'd0, busy}, 16'h0);
    tb_en = 1'b0;
    #1;
    chk("cont_release", dq, 16'hFFFF);
    idle_pins();
    m_cont = 1'b1;
    step();
    rd(18'h004, 1'b0, 1'b0, "post_cont");
    chk_cnt("cont");

    wr(18'h00400, 16'h7777, 1'b0, 1'b0);
    chk_cnt("oob_wr");
    rd(18'h00401, 1'b0, 1'b0, "oob_rd");
    chk_cnt("oob_rd");

    for (int i = 0; i < 8; i++) begin
      ra[i] = 18'($urandom_range(32, 1023));
      wr(ra[i], 16'($urandom), 1'b0, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1)
        wr(ra[k], 16'($urandom), 1'($urandom), 1'($urandom));
      else
        rd(ra[k], 1'($urandom), 1'($urandom), "rand_rd");
    end
    chk_cnt("rand");
    chk("sb_empty", 16'(sb.size()), 16'h0);

    // One-cycle latency responder: each address toggle is a new read
    f_ce_n = 1'b0; f_oe_n = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      f_addr = 18'(i & 1);
      step();
      if (i == 99) chk("fast_count_100", f_rd_count, 16'd100);
    end
    chk("fast_sat", f_rd_count, 16'hFFFF);
    f_ce_n = 1'b1; f_oe_n = 1'b1;
    step();
    step();
    chk("fast_sat_hold", f_rd_count, 16'hFFFF);
    chk("fast_idle", {15'd0, f_busy}, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
